// File: rtl/perf_pkg.sv
// Shared constants for the pipeline performance counter bank: counting
// modes and the event channel assignment used by the mp4 core hookup.
package perf_pkg;

    localparam logic MODE_LEVEL = 1'b0;
    localparam logic MODE_EDGE  = 1'b1;

    localparam int EV_I_HIT      = 0;
    localparam int EV_I_MISS     = 1;
    localparam int EV_D_HIT      = 2;
    localparam int EV_D_MISS     = 3;
    localparam int EV_MISPREDICT = 4;
    localparam int EV_STALL_ALL  = 5;
    localparam int EV_STALL_FE   = 6;
    localparam int EV_STALL_EMW  = 7;

endpackage

// File: rtl/perf_event_counter.sv
// One counter channel: event qualification (level or rising edge),
// saturating/wrapping counter and sticky overflow flag.
module perf_event_counter
    import perf_pkg::*;
#(
    parameter int CNT_WIDTH = 32,
    parameter bit SATURATE  = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 event_i,
    input  logic                 enable,
    input  logic                 edge_mode,
    input  logic                 clear,
    output logic [CNT_WIDTH-1:0] cnt,
    output logic                 ovf
);

    logic prev_p0;
    logic hit;

    function automatic logic [CNT_WIDTH-1:0] bump(input logic [CNT_WIDTH-1:0] v);
        if (v == '1) begin
            return SATURATE ? v : '0;
        end
        return v + CNT_WIDTH'(1);
    endfunction

    // prev tracks the raw strobe even while disabled, so enabling during a
    // high event does not fabricate an edge.
    assign hit = enable & ((edge_mode == MODE_EDGE) ? (event_i & ~prev_p0) : event_i);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_p0 <= 1'b0;
            cnt     <= '0;
            ovf     <= 1'b0;
        end else begin
            prev_p0 <= event_i;
            if (clear) begin
                cnt <= '0;
                ovf <= 1'b0;
            end else if (hit) begin
                cnt <= bump(cnt);
                if (cnt == '1) begin
                    ovf <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/perf_counter_bank.sv
// Bank of NUM_CH event counters with an atomic shadow snapshot and a
// two-edge read pipeline (latch select, then present shadow value).
module perf_counter_bank
    import perf_pkg::*;
#(
    parameter int NUM_CH    = 8,
    parameter int CNT_WIDTH = 32,
    parameter bit SATURATE  = 1'b1,
    parameter int SEL_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_CH-1:0]    event_i,
    input  logic [NUM_CH-1:0]    enable,
    input  logic [NUM_CH-1:0]    edge_mode,
    input  logic                 clear,
    input  logic                 snap_req,
    input  logic                 rd_req,
    input  logic [SEL_W-1:0]     rd_sel,
    output logic [CNT_WIDTH-1:0] rd_data,
    output logic                 rd_valid,
    output logic [NUM_CH-1:0]    ovf
);

    logic [CNT_WIDTH-1:0] cnt    [NUM_CH];
    logic [CNT_WIDTH-1:0] shadow [NUM_CH];
    logic [SEL_W-1:0]     rd_sel_p0;
    logic                 vld_p0;
    logic [CNT_WIDTH-1:0] rd_mux;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        perf_event_counter #(
            .CNT_WIDTH (CNT_WIDTH),
            .SATURATE  (SATURATE)
        ) u_ch (
            .clk       (clk),
            .rst_n     (rst_n),
            .event_i   (event_i[i]),
            .enable    (enable[i]),
            .edge_mode (edge_mode[i]),
            .clear     (clear),
            .cnt       (cnt[i]),
            .ovf       (ovf[i])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++) shadow[i] <= '0;
        end else if (snap_req) begin
            for (int i = 0; i < NUM_CH; i++) shadow[i] <= cnt[i];
        end
    end

    // Unmatched select (rd_sel >= NUM_CH) falls through to zero.
    always_comb begin
        rd_mux = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (rd_sel_p0 == SEL_W'(i)) rd_mux = shadow[i];
        end
    end

    // Stage p0: latch the request; output stage: present shadow value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p0    <= 1'b0;
            rd_sel_p0 <= '0;
            rd_valid  <= 1'b0;
            rd_data   <= '0;
        end else begin
            vld_p0   <= rd_req;
            rd_valid <= vld_p0;
            if (rd_req) rd_sel_p0 <= rd_sel;
            if (vld_p0) rd_data <= rd_mux;
        end
    end

endmodule
